// File: rtl/hazard_ctrl.sv
// Pipeline hazard scheduler: load-use interlock, taken-branch squash window and data-memory freeze.
// Optional perf counters (stall_cnt/flush_cnt) are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int unsigned BR_PENALTY = 2,
  parameter int unsigned CNT_W      = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_br_taken,
  input  logic       dmem_busy,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_stall
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int unsigned FL_W = $clog2(BR_PENALTY) + 1;
  localparam logic [FL_W-1:0] FL_RELOAD = FL_W'(BR_PENALTY - 1);

  if (BR_PENALTY < 1 || CNT_W < 1) begin : g_param_check
    $error("hazard_ctrl: BR_PENALTY and CNT_W must both be >= 1");
  end

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_MEMW  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [FL_W-1:0] r_flush_left;
  logic [FL_W-1:0] w_flush_left_nxt;
  logic            w_lu;
  logic            w_window;

  assign w_lu = ex_mem_read && (ex_rd != 5'd0) &&
                ((id_rs1_used && (id_rs1 == ex_rd)) ||
                 (id_rs2_used && (id_rs2 == ex_rd)));

  // A remaining window is honoured both in S_FLUSH and when leaving S_MEMW.
  assign w_window = (r_state != S_RUN) && (r_flush_left != '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_RUN;
      r_flush_left <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_left <= w_flush_left_nxt;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt      = r_state;
    w_flush_left_nxt = r_flush_left;
    pc_stall         = 1'b0;
    if_id_stall      = 1'b0;
    if_id_flush      = 1'b0;
    id_ex_flush      = 1'b0;
    ex_mem_stall     = 1'b0;

    if (!rst) begin
      w_state_nxt      = S_RUN;
      w_flush_left_nxt = '0;
    end else if (dmem_busy) begin
      // EX is frozen, so branch and load-use are re-evaluated after the wait.
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      w_state_nxt  = S_MEMW;
    end else if (ex_br_taken) begin
      if_id_flush      = 1'b1;
      id_ex_flush      = 1'b1;
      w_flush_left_nxt = FL_RELOAD;
      w_state_nxt      = (BR_PENALTY > 1) ? S_FLUSH : S_RUN;
    end else if (w_window) begin
      if_id_flush      = 1'b1;
      w_flush_left_nxt = r_flush_left - 1'b1;
      w_state_nxt      = (r_flush_left == FL_W'(1)) ? S_RUN : S_FLUSH;
    end else begin
      w_state_nxt = S_RUN;
      if (w_lu) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (pc_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (if_id_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed hazard scenarios followed by random traffic,
// checked against a rule-level model of the scheduler (counters checked with HAZARD_PERF_CNT_EN).
module tb_hazard_ctrl;

  localparam int unsigned BRP   = 2;
  localparam int unsigned CNT_W = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, ex_mem_read, ex_br_taken, dmem_busy;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.BR_PENALTY(BRP), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .ex_br_taken  (ex_br_taken),
    .dmem_busy    (dmem_busy),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_stall (ex_mem_stall)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  // ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall}
  typedef struct {
    logic [4:0]       ctl;
    logic             cnt_known;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
    string            tag;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   stim_done = 1'b0;

  // Model state: pending IF/ID flush cycles after a taken branch, and counter images.
  int               m_left = 0;
  logic             m_cnt_known = 1'b0;
  logic [CNT_W-1:0] m_sc = '0;
  logic [CNT_W-1:0] m_fc = '0;

  task automatic check(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input string tag, input logic r, input logic busy, input logic br,
                       input logic ld, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2);
    exp_t e;
    logic lu;
    rst = r; dmem_busy = busy; ex_br_taken = br; ex_mem_read = ld; ex_rd = rd;
    id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;

    lu = ld && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    e.tag       = tag;
    e.ctl       = 5'b00000;
    e.cnt_known = m_cnt_known;
    e.sc        = m_sc;
    e.fc        = m_fc;

    if (!r) begin
      m_left = 0;
    end else if (busy) begin
      e.ctl = 5'b11001;              // freeze everything, window untouched
    end else if (br) begin
      e.ctl  = 5'b00110;             // squash IF/ID and ID/EX, PC takes target
      m_left = BRP - 1;
    end else if (m_left > 0) begin
      e.ctl  = 5'b00100;             // IF/ID keeps receiving bubbles
      m_left = m_left - 1;
    end else if (lu) begin
      e.ctl = 5'b11010;              // interlock one cycle
    end

    if (!r) begin
      m_sc = '0; m_fc = '0; m_cnt_known = 1'b1;
    end else begin
      if (e.ctl[4] && m_sc != '1) m_sc = m_sc + 1'b1;
      if (e.ctl[2] && m_fc != '1) m_fc = m_fc + 1'b1;
    end

    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) drive(tag, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle once the stimulus has settled.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check({e.tag, ".ctl"}, CNT_W'({pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall}),
              CNT_W'(e.ctl));
`ifdef HAZARD_PERF_CNT_EN
        if (e.cnt_known) begin
          check({e.tag, ".stall_cnt"}, stall_cnt, e.sc);
          check({e.tag, ".flush_cnt"}, flush_cnt, e.fc);
        end
`endif
      end
    end
  end

  initial begin
    logic [4:0] rd, r1, r2;
    rst = 1'b0; dmem_busy = 1'b0; ex_br_taken = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
    id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    @(posedge clk);
    #1;

    drive("reset0", 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1);
    drive("reset1", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);

    drive("lu_rs1",   1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    drive("lu_after", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0);
    drive("lu_x0",    1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    drive("lu_rs2_unused", 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b0);
    drive("lu_rs2",   1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1);

    drive("br", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    idle("br_tail", 2);

    drive("br_lu", 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1);
    drive("br_lu_win", 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    idle("br_lu_tail", 1);

    drive("br_busy", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++)
      drive("busy_win", 1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 5'd4, 1'b1, 5'd4, 1'b1);
    drive("busy_exit", 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    drive("busy_run",  1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0);

    drive("br_rst", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    drive("rst_in_flush", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    idle("after_rst", 2);

    for (int i = 0; i < 4; i++) begin
      drive("lu4", 1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 5'd1, 1'b0, 5'd12, 1'b1);
      idle("lu4_gap", 1);
    end
    idle("lu4_end", 1);

    for (int i = 0; i < 400; i++) begin
      rd = 5'($urandom_range(0, 3));
      r1 = 5'($urandom_range(0, 3));
      r2 = 5'($urandom_range(0, 3));
      drive("rand", ($urandom_range(0, 99) >= 3), ($urandom_range(0, 99) < 20),
            ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 50), rd,
            r1, 1'($urandom_range(0, 1)), r2, 1'($urandom_range(0, 1)));
    end
    idle("drain", 1);
    stim_done = 1'b1;
  end

  initial begin
    wait (stim_done);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: actual=%0d pending required=0", q.size());
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

endmodule
